// File: rtl/isa_pkg.sv
// Shared instruction-set definitions for the encoder/loader: field widths,
// bit positions of each field in the packed word, opcode names and FSM states.
package isa_pkg;

  localparam int OP_W    = 5;
  localparam int REG_W   = 4;
  localparam int IMM_W   = 16;
  localparam int INSTR_W = OP_W + 3 * REG_W + IMM_W;

  localparam int OP_MSB  = 32;
  localparam int RD_LSB  = 24;
  localparam int RS1_LSB = 20;
  localparam int RS2_LSB = 16;
  localparam int IMM_LSB = 0;

  localparam logic [OP_W-1:0] OPC_NOP  = 5'h00;
  localparam logic [OP_W-1:0] OPC_ADDI = 5'h01;
  localparam logic [OP_W-1:0] OPC_ADD  = 5'h02;
  localparam logic [OP_W-1:0] OPC_SUB  = 5'h03;
  localparam logic [OP_W-1:0] OPC_LD   = 5'h04;
  localparam logic [OP_W-1:0] OPC_ST   = 5'h05;
  localparam logic [OP_W-1:0] OPC_BEQ  = 5'h0E;
  localparam logic [OP_W-1:0] OPC_JAL  = 5'h10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/encode_instruction.sv
// Combinational field packer; the exact inverse of the instruction decoder's
// field extraction, so every field lands at the position the decoder reads.
module encode_instruction
  import isa_pkg::*;
(
  input  logic [OP_W-1:0]    i_opcode,
  input  logic [REG_W-1:0]   i_rd,
  input  logic [REG_W-1:0]   i_rs1,
  input  logic [REG_W-1:0]   i_rs2,
  input  logic [IMM_W-1:0]   i_imm,
  output logic [INSTR_W-1:0] o_word
);

  always_comb begin
    o_word                      = '0;
    o_word[OP_MSB -: OP_W]      = i_opcode;
    o_word[RD_LSB +: REG_W]     = i_rd;
    o_word[RS1_LSB +: REG_W]    = i_rs1;
    o_word[RS2_LSB +: REG_W]    = i_rs2;
    o_word[IMM_LSB +: IMM_W]    = i_imm;
  end

endmodule

// File: rtl/instruction_encoder_loader.sv
// Accepts instruction field tuples, packs them into words and streams them into
// instruction memory at consecutive addresses from a programmable start address.
module instruction_encoder_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8
)
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_start_addr,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [OP_W-1:0]     i_in_opcode,
  input  logic [REG_W-1:0]    i_in_rd,
  input  logic [REG_W-1:0]    i_in_rs1,
  input  logic [REG_W-1:0]    i_in_rs2,
  input  logic [IMM_W-1:0]    i_in_imm,
  input  logic                i_in_last,
  output logic                o_mem_we,
  input  logic                i_mem_ready,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [INSTR_W-1:0]  o_mem_wdata,
  output logic                o_busy,
  output logic                o_done,
  output logic [ADDR_W:0]     o_wr_count,
  output logic                o_overflow
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]         r_state;
  logic [ADDR_W-1:0]  r_wptr;
  logic [ADDR_W:0]    r_wr_count;
  logic               r_done;
  logic               r_overflow;
  logic               r_out_valid;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;

  logic [INSTR_W-1:0] w_word;
  logic               w_in_ready;
  logic               w_accept;
  logic               w_wr_done;
  logic               w_at_end;

  encode_instruction u_encode (
    .i_opcode (i_in_opcode),
    .i_rd     (i_in_rd),
    .i_rs1    (i_in_rs1),
    .i_rs2    (i_in_rs2),
    .i_imm    (i_in_imm),
    .o_word   (w_word)
  );

  // The output register may refill on the same edge its word is consumed.
  assign w_in_ready = (r_state == ST_LOAD) & (~r_out_valid | i_mem_ready);
  assign w_accept   = i_in_valid & w_in_ready;
  assign w_wr_done  = r_out_valid & i_mem_ready;
  assign w_at_end   = (r_wptr == LAST_ADDR);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_wptr     <= '0;
      r_wr_count <= '0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_done) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state    <= ST_LOAD;
            r_wptr     <= i_start_addr;
            r_wr_count <= '0;
            r_overflow <= 1'b0;
          end
        end
        ST_LOAD: begin
          // The top address is written once and the pointer parks there.
          if (w_accept) begin
            if (!w_at_end) begin
              r_wptr <= r_wptr + 1'b1;
            end
            if (i_in_last || w_at_end) begin
              r_state <= ST_FLUSH;
            end
            if (w_at_end && !i_in_last) begin
              r_overflow <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (w_wr_done) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_mem_addr  <= r_wptr;
      r_mem_wdata <= w_word;
    end else if (w_wr_done) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_mem_we    = r_out_valid;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = (r_state == ST_LOAD) | (r_state == ST_FLUSH);
  assign o_done      = r_done;
  assign o_wr_count  = r_wr_count;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_instruction_encoder_loader.sv
// Scoreboard bench for instruction_encoder_loader: directed tuples push their
// hand-computed address/word into a queue that a write monitor drains.
module tb_instruction_encoder_loader;
  import isa_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  startAddr;
  logic        inValid;
  logic        inReady;
  logic [4:0]  inOpcode;
  logic [3:0]  inRd;
  logic [3:0]  inRs1;
  logic [3:0]  inRs2;
  logic [15:0] inImm;
  logic        inLast;
  logic        memWe;
  logic        memReady;
  logic [7:0]  memAddr;
  logic [32:0] memWdata;
  logic        busy;
  logic        done;
  logic [8:0]  wrCount;
  logic        overflow;

  typedef struct packed {
    logic [7:0]  addr;
    logic [32:0] word;
  } exp_t;

  exp_t sbQueue[$];
  int   checks = 0;
  int   errors = 0;
  int   waits;

  instruction_encoder_loader #(.ADDR_W(8)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_start_addr (startAddr),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .i_in_opcode  (inOpcode),
    .i_in_rd      (inRd),
    .i_in_rs1     (inRs1),
    .i_in_rs2     (inRs2),
    .i_in_imm     (inImm),
    .i_in_last    (inLast),
    .o_mem_we     (memWe),
    .i_mem_ready  (memReady),
    .o_mem_addr   (memAddr),
    .o_mem_wdata  (memWdata),
    .o_busy       (busy),
    .o_done       (done),
    .o_wr_count   (wrCount),
    .o_overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                               input logic [3:0] rs2, input logic [15:0] imm, input logic last,
                               input logic [32:0] expWord, input logic [7:0] expAddr,
                               input logic expectWrite, output int waited);
    exp_t e;
    logic accepted;
    if (expectWrite) begin
      e.addr = expAddr;
      e.word = expWord;
      sbQueue.push_back(e);
    end
    inOpcode = op; inRd = rd; inRs1 = rs1; inRs2 = rs2; inImm = imm; inLast = last;
    inValid  = 1'b1;
    accepted = 1'b0;
    waited   = 0;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (inReady) accepted = 1'b1;
      @(posedge clk);
      #1;
      if (!accepted) waited++;
    end
    if (!accepted) checkOutput("accept_timeout", 64'd0, 64'd1);
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic pulseStart(input logic [7:0] addr);
    start     = 1'b1;
    startAddr = addr;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_seen", 64'(done), 64'd1);
    checkOutput("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    checkOutput("done_pulse_width", 64'(done), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completed memory write must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && memWe && memReady) begin
        if (sbQueue.size() == 0) begin
          checkOutput("unexpected_write_addr", 64'(memAddr), 64'hFFFF);
        end else begin
          e = sbQueue.pop_front();
          checkOutput("wr_addr", 64'(memAddr), 64'(e.addr));
          checkOutput("wr_data", 64'(memWdata), 64'(e.word));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic sawReady;
    logic sawDone;
    rst = 1'b1; start = 1'b0; startAddr = '0; inValid = 1'b0; inLast = 1'b0;
    inOpcode = '0; inRd = '0; inRs1 = '0; inRs2 = '0; inImm = '0; memReady = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(inReady), 64'd0);
    checkOutput("rst_mem_we", 64'(memWe), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_mem_addr", 64'(memAddr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(memWdata), 64'd0);
    checkOutput("rst_wr_count", 64'(wrCount), 64'd0);
    @(posedge clk);
    #1;

    $display("[TB] basic two-word session");
    pulseStart(8'h10);
    applyStimulus(OPC_ADDI, 4'd1, 4'd0, 4'd0, 16'h0010, 1'b0, 33'h011000010, 8'h10, 1'b1, waits);
    applyStimulus(OPC_ADDI, 4'd2, 4'd0, 4'd0, 16'h0020, 1'b1, 33'h012000020, 8'h11, 1'b1, waits);
    waitDone();
    checkOutput("t1_wr_count", 64'(wrCount), 64'd2);

    $display("[TB] opcode MSB placement");
    pulseStart(8'h20);
    applyStimulus(OPC_BEQ, 4'd1, 4'd3, 4'd0, 16'hFFFD, 1'b0, 33'h0E130FFFD, 8'h20, 1'b1, waits);
    applyStimulus(5'h13, 4'd15, 4'd0, 4'd9, 16'h8000, 1'b1, 33'h13F098000, 8'h21, 1'b1, waits);
    waitDone();
    checkOutput("t2_wr_count", 64'(wrCount), 64'd2);

    $display("[TB] back-pressure then full throughput");
    pulseStart(8'h30);
    applyStimulus(OPC_ST, 4'd2, 4'd2, 4'd1, 16'h0000, 1'b0, 33'h052210000, 8'h30, 1'b1, waits);
    memReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_mem_we", 64'(memWe), 64'd1);
      checkOutput("stall_mem_addr", 64'(memAddr), 64'h30);
      checkOutput("stall_mem_wdata", 64'(memWdata), 64'h052210000);
      checkOutput("stall_in_ready", 64'(inReady), 64'd0);
    end
    @(posedge clk);
    #1 memReady = 1'b1;
    applyStimulus(OPC_ADD, 4'd3, 4'd4, 4'd5, 16'h0001, 1'b0, 33'h023450001, 8'h31, 1'b1, waits);
    checkOutput("thru_wait_b", 64'(waits), 64'd0);
    applyStimulus(5'h1F, 4'd15, 4'd15, 4'd15, 16'hFFFF, 1'b0, 33'h1FFFFFFFF, 8'h32, 1'b1, waits);
    checkOutput("thru_wait_c", 64'(waits), 64'd0);
    applyStimulus(OPC_NOP, 4'd0, 4'd0, 4'd0, 16'h7FFF, 1'b1, 33'h000007FFF, 8'h33, 1'b1, waits);
    checkOutput("thru_wait_d", 64'(waits), 64'd0);
    waitDone();
    checkOutput("t3_wr_count", 64'(wrCount), 64'd4);

    $display("[TB] address space end");
    pulseStart(8'hFE);
    applyStimulus(5'h07, 4'd1, 4'd2, 4'd3, 16'h00AA, 1'b0, 33'h0712300AA, 8'hFE, 1'b1, waits);
    applyStimulus(5'h08, 4'd4, 4'd4, 4'd4, 16'h0055, 1'b0, 33'h084440055, 8'hFF, 1'b1, waits);
    inOpcode = 5'h09; inRd = 4'd5; inRs1 = 4'd5; inRs2 = 4'd5; inImm = 16'h0099; inLast = 1'b0;
    inValid  = 1'b1;
    sawReady = 1'b0;
    sawDone  = 1'b0;
    for (int i = 0; i < 20 && !sawDone; i++) begin
      @(negedge clk);
      if (inReady) sawReady = 1'b1;
      if (done) sawDone = 1'b1;
    end
    checkOutput("t4_third_not_ready", 64'(sawReady), 64'd0);
    checkOutput("t4_done_seen", 64'(sawDone), 64'd1);
    checkOutput("t4_overflow", 64'(overflow), 64'd1);
    checkOutput("t4_wr_count", 64'(wrCount), 64'd2);
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t4_overflow_sticky", 64'(overflow), 64'd1);

    $display("[TB] reset mid-session");
    pulseStart(8'h40);
    checkOutput("t5_overflow_cleared", 64'(overflow), 64'd0);
    applyStimulus(OPC_LD, 4'd0, 4'd1, 4'd2, 16'h0400, 1'b0, 33'h040120400, 8'h40, 1'b1, waits);
    @(posedge clk);
    #1 memReady = 1'b0;
    applyStimulus(5'h06, 4'd6, 4'd6, 4'd6, 16'h6666, 1'b0, 33'h066606666, 8'h41, 1'b0, waits);
    @(negedge clk);
    checkOutput("t5_pre_mem_we", 64'(memWe), 64'd1);
    checkOutput("t5_pre_wr_count", 64'(wrCount), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_mem_we", 64'(memWe), 64'd0);
    checkOutput("t5_rst_busy", 64'(busy), 64'd0);
    checkOutput("t5_rst_mem_addr", 64'(memAddr), 64'd0);
    checkOutput("t5_rst_mem_wdata", 64'(memWdata), 64'd0);
    checkOutput("t5_rst_wr_count", 64'(wrCount), 64'd0);
    checkOutput("t5_rst_in_ready", 64'(inReady), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 memReady = 1'b1;
    pulseStart(8'h00);
    applyStimulus(OPC_SUB, 4'd4, 4'd5, 4'd6, 16'h1234, 1'b1, 33'h034561234, 8'h00, 1'b1, waits);
    waitDone();
    checkOutput("t5_wr_count", 64'(wrCount), 64'd1);

    $display("[TB] start during LOAD and valid during IDLE");
    pulseStart(8'h50);
    applyStimulus(5'h0A, 4'd1, 4'd1, 4'd1, 16'h0101, 1'b0, 33'h0A1110101, 8'h50, 1'b1, waits);
    @(posedge clk);
    #1;
    pulseStart(8'h00);
    checkOutput("t6_wr_count_kept", 64'(wrCount), 64'd1);
    applyStimulus(5'h0B, 4'd2, 4'd2, 4'd2, 16'h0202, 1'b1, 33'h0B2220202, 8'h51, 1'b1, waits);
    waitDone();
    checkOutput("t6_wr_count", 64'(wrCount), 64'd2);
    inOpcode = OPC_JAL; inImm = 16'hBEEF; inValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("idle_in_ready", 64'(inReady), 64'd0);
      checkOutput("idle_mem_we", 64'(memWe), 64'd0);
    end
    @(posedge clk);
    #1 inValid = 1'b0;

    repeat (2) @(posedge clk);
    checkOutput("sb_empty", 64'(sbQueue.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
